// File: rtl/nicojeda_prbs31_if.sv
// Tiny-Tapeout pin bundle for the PRBS31 tile: enable plus the three 8-bit pin groups.
interface nicojeda_prbs31_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/nicojeda_prbs31.sv
// PRBS31 (x^31+x^28+1) pattern generator plus self-synchronising checker with saturating error count.
// Optional macro PRBS31_LOOPBACK_EN: ui_in[7]=1 feeds the internal tx stream into the checker.
module nicojeda_prbs31 #(
  parameter logic [30:0] SEED       = 31'h7FFF_FFFF,
  parameter int          LOCK_LEN   = 32,
  parameter int          UNLOCK_ERR = 4
) (
  input logic              clk,
  input logic              rst,
  nicojeda_prbs31_if.slave bus
);
  // state  | meaning
  // HUNT   | counting consecutive error-free bits toward lock
  // LOCKED | counting errors; too many in one window returns to HUNT
  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} lock_state_t;

  localparam int RUN_W   = $clog2(LOCK_LEN + 1);
  localparam int WERR_W  = $clog2(UNLOCK_ERR + 1);
  localparam int WIN_LEN = 32;

  lock_state_t       state;
  lock_state_t       state_nxt;
  logic [30:0]       lfsr;
  logic [30:0]       hist;
  logic              inj_q;
  logic              inj_prev;
  logic              err_pulse;
  logic [7:0]        err_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [4:0]        win_cnt;
  logic [WERR_W-1:0] win_err;
  logic [WERR_W:0]   win_err_sum;

  logic ena;
  logic advance;
  logic chk;
  logic invert;
  logic inj_rise;
  logic err_clr;
  logic tx;
  logic rx_src;
  logic rx;
  logic pred;
  logic err;
  logic locked;
  logic run_hit;
  logic unlock_hit;
  logic unused_ok;

  assign ena      = bus.ena;
  assign advance  = ena & bus.ui_in[0];
  assign chk      = ena & bus.ui_in[3];
  assign invert   = bus.ui_in[1];
  assign err_clr  = bus.ui_in[5];
  assign inj_rise = bus.ui_in[2] & ~inj_prev;
  assign locked   = (state == LOCKED);

  assign tx = lfsr[30] ^ invert ^ inj_q;

`ifdef PRBS31_LOOPBACK_EN
  assign rx_src    = bus.ui_in[7] ? tx : bus.ui_in[4];
  assign unused_ok = ^{bus.uio_in, bus.ui_in[6]};
`else
  assign rx_src    = bus.ui_in[4];
  assign unused_ok = ^{bus.uio_in, bus.ui_in[7:6]};
`endif

  // Invert applies on the receive side too, so a looped-back inverted stream checks clean.
  assign rx   = rx_src ^ invert;
  assign pred = hist[30] ^ hist[27];
  assign err  = (rx != pred);

  assign win_err_sum = {1'b0, win_err} + {{WERR_W{1'b0}}, err};
  assign run_hit     = chk && !locked && !err && (run_cnt == RUN_W'(LOCK_LEN - 1));
  assign unlock_hit  = chk && locked && err && (win_err_sum >= (WERR_W + 1)'(UNLOCK_ERR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (run_hit)    state_nxt = LOCKED;
      LOCKED:  if (unlock_hit) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= SEED;
      inj_q    <= 1'b0;
      inj_prev <= 1'b0;
    end else if (ena) begin
      inj_prev <= bus.ui_in[2];
      if (lfsr == 31'd0) begin
        lfsr <= SEED;
      end else if (advance) begin
        lfsr <= {lfsr[29:0], lfsr[30] ^ lfsr[27]};
      end
      // The injected flip lives exactly until the next transmitted bit moves on.
      if (advance && inj_q) begin
        inj_q <= 1'b0;
      end else if (inj_rise) begin
        inj_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= 31'd0;
      run_cnt   <= '0;
      win_cnt   <= 5'd0;
      win_err   <= '0;
      err_pulse <= 1'b0;
    end else if (chk) begin
      hist      <= {hist[29:0], rx};
      err_pulse <= err & locked;
      if (!locked) begin
        win_cnt <= 5'd0;
        win_err <= '0;
        if (err || run_hit) begin
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + 1'b1;
        end
      end else begin
        run_cnt <= '0;
        if (unlock_hit || (win_cnt == 5'(WIN_LEN - 1))) begin
          win_cnt <= 5'd0;
          win_err <= '0;
        end else begin
          win_cnt <= win_cnt + 1'b1;
          win_err <= win_err_sum[WERR_W-1:0];
        end
      end
    end else if (ena) begin
      err_pulse <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (ena) begin
      if (err_clr) begin
        err_cnt <= 8'd0;
      end else if (chk && locked && err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign bus.uo_out  = {lfsr[3:0], (err_cnt == 8'hFF), err_pulse, locked, tx};
  assign bus.uio_out = err_cnt;
  assign bus.uio_oe  = 8'hFF;
endmodule

// File: tb/tb_nicojeda_prbs31.sv
// Directed bench for nicojeda_prbs31: tx sequence, lock acquisition, injection, saturation, freeze, invert.
// The checker input is fed from tx by the bench when loopback is wanted, so both macro builds behave alike.
module tb_nicojeda_prbs31;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nicojeda_prbs31_if bus ();
  nicojeda_prbs31 dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  logic [7:0] ctrl;
  logic ext_loop;
  logic rx_drive;
  logic ena_v;
  int pos;
  logic s [0:511];

  task automatic apply();
    bus.ena    = ena_v;
    bus.ui_in  = ctrl;
    bus.ui_in[4] = rx_drive;
    bus.ui_in[7] = ext_loop;
    bus.uio_in = 8'hA5;
    #1;
    if (ext_loop) bus.ui_in[4] = bus.uo_out[0];
  endtask

  task automatic cyc();
    @(posedge clk);
    if (ena_v && ctrl[0]) pos++;
    #1;
    if (ext_loop) bus.ui_in[4] = bus.uo_out[0];
  endtask

  task automatic do_reset();
    rst = 1'b1; ena_v = 1'b1; ctrl = 8'h00; ext_loop = 1'b0; rx_drive = 1'b0;
    apply();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pos = 0;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    do_reset();
    ctrl = 8'h01; apply();
    repeat (5) cyc();
    exp = {s[32], s[33], s[34], s[35], 3'b000, s[5]};
    checks++;
    if (bus.uo_out !== exp) begin
      failures++; $display("FAIL pre_reset_uo got=%h exp=%h", bus.uo_out, exp);
    end
    rst = 1'b1; ena_v = 1'b0; apply();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; pos = 0;
    checks++;
    if (bus.uo_out !== 8'hF1) begin
      failures++; $display("FAIL reset_uo got=%h exp=f1", bus.uo_out);
    end
    checks++;
    if (bus.uio_out !== 8'h00) begin
      failures++; $display("FAIL reset_cnt got=%h exp=00", bus.uio_out);
    end
    checks++;
    if (bus.uio_oe !== 8'hFF) begin
      failures++; $display("FAIL reset_oe got=%h exp=ff", bus.uio_oe);
    end
  endtask

  task automatic test_tx_sequence();
    logic [3:0] nib;
    do_reset();
    ctrl = 8'h01; apply();
    checks++;
    if (bus.uo_out[0] !== s[0]) begin
      failures++; $display("FAIL tx_seq pos=0 got=%b exp=%b", bus.uo_out[0], s[0]);
    end
    for (int k = 1; k <= 40; k++) begin
      cyc();
      checks++;
      if (bus.uo_out[0] !== s[pos]) begin
        failures++; $display("FAIL tx_seq pos=%0d got=%b exp=%b", pos, bus.uo_out[0], s[pos]);
      end
      checks++;
      if (bus.uio_oe !== 8'hFF) begin
        failures++; $display("FAIL tx_seq_oe pos=%0d got=%h exp=ff", pos, bus.uio_oe);
      end
    end
    nib = {s[pos+27], s[pos+28], s[pos+29], s[pos+30]};
    checks++;
    if (bus.uo_out[7:4] !== nib) begin
      failures++; $display("FAIL tx_nibble got=%h exp=%h", bus.uo_out[7:4], nib);
    end
  endtask

  task automatic test_lock();
    int pulses = 0;
    do_reset();
    ext_loop = 1'b1;
    ctrl = 8'h09; apply();
    for (int n = 1; n <= 100; n++) begin
      cyc();
      if (bus.uo_out[2] === 1'b1) pulses++;
      if (n == 59) begin
        checks++;
        if (bus.uo_out[1] !== 1'b0) begin
          failures++; $display("FAIL lock_early got=%b exp=0", bus.uo_out[1]);
        end
      end
      if (n == 60) begin
        checks++;
        if (bus.uo_out[1] !== 1'b1) begin
          failures++; $display("FAIL lock_at_60 got=%b exp=1", bus.uo_out[1]);
        end
      end
    end
    checks++;
    if (pulses !== 0) begin
      failures++; $display("FAIL lock_pulses got=%0d exp=0", pulses);
    end
    checks++;
    if (bus.uio_out !== 8'h00) begin
      failures++; $display("FAIL lock_cnt got=%h exp=00", bus.uio_out);
    end
  endtask

  task automatic test_inject();
    int pcnt = 0;
    int pat [3] = '{0, 0, 0};
    ctrl[2] = 1'b1; apply();
    cyc();
    checks++;
    if (bus.uo_out[0] !== ~s[pos]) begin
      failures++; $display("FAIL inj_flip pos=%0d got=%b exp=%b", pos, bus.uo_out[0], ~s[pos]);
    end
    ctrl[2] = 1'b0; apply();
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (n == 1) begin
        checks++;
        if (bus.uo_out[0] !== s[pos]) begin
          failures++; $display("FAIL inj_one_bit pos=%0d got=%b exp=%b", pos, bus.uo_out[0], s[pos]);
        end
      end
      if (bus.uo_out[2] === 1'b1) begin
        if (pcnt < 3) pat[pcnt] = n;
        pcnt++;
      end
    end
    checks++;
    if (pcnt !== 3) begin
      failures++; $display("FAIL inj_pulse_count got=%0d exp=3", pcnt);
    end
    checks++;
    if (pat[0] !== 1 || pat[1] !== 29 || pat[2] !== 32) begin
      failures++; $display("FAIL inj_pulse_times got=%0d,%0d,%0d exp=1,29,32", pat[0], pat[1], pat[2]);
    end
    checks++;
    if (bus.uio_out !== 8'd3) begin
      failures++; $display("FAIL inj_cnt got=%0d exp=3", bus.uio_out);
    end
    checks++;
    if (bus.uo_out[1] !== 1'b1) begin
      failures++; $display("FAIL inj_lock got=%b exp=1", bus.uo_out[1]);
    end
  endtask

  task automatic test_saturate();
    int n = 0;
    for (int k = 1; k <= 86; k++) begin
      ctrl[2] = 1'b1; apply();
      cyc();
      ctrl[2] = 1'b0; apply();
      repeat (63) cyc();
      if (k == 83) begin
        checks++;
        if (bus.uio_out !== 8'd252 || bus.uo_out[3] !== 1'b0) begin
          failures++; $display("FAIL sat_below got=%0d/%b exp=252/0", bus.uio_out, bus.uo_out[3]);
        end
      end
      if (k == 84) begin
        checks++;
        if (bus.uio_out !== 8'd255 || bus.uo_out[3] !== 1'b1) begin
          failures++; $display("FAIL sat_reach got=%0d/%b exp=255/1", bus.uio_out, bus.uo_out[3]);
        end
      end
    end
    checks++;
    if (bus.uio_out !== 8'd255 || bus.uo_out[1] !== 1'b1) begin
      failures++; $display("FAIL sat_hold got=%0d/lock%b exp=255/lock1", bus.uio_out, bus.uo_out[1]);
    end
    ext_loop = 1'b0; rx_drive = 1'b0; apply();
    while (bus.uo_out[1] === 1'b1 && n < 60) begin
      cyc();
      n++;
    end
    checks++;
    if (bus.uo_out[1] !== 1'b0) begin
      failures++; $display("FAIL rx0_unlock got=%b exp=0 after %0d clks", bus.uo_out[1], n);
    end
    checks++;
    if (bus.uio_out !== 8'd255) begin
      failures++; $display("FAIL rx0_cnt got=%0d exp=255", bus.uio_out);
    end
    ctrl[5] = 1'b1; apply();
    cyc();
    checks++;
    if (bus.uio_out !== 8'd0 || bus.uo_out[3] !== 1'b0) begin
      failures++; $display("FAIL clear got=%0d/%b exp=0/0", bus.uio_out, bus.uo_out[3]);
    end
    ctrl[5] = 1'b0; apply();
  endtask

  task automatic test_freeze();
    logic [7:0] exp;
    do_reset();
    ext_loop = 1'b1;
    ctrl = 8'h09; apply();
    repeat (70) cyc();
    ctrl[2] = 1'b1; apply();
    cyc();
    ctrl[2] = 1'b0; apply();
    repeat (40) cyc();
    ena_v = 1'b0; apply();
    exp = {s[pos+27], s[pos+28], s[pos+29], s[pos+30], 3'b001, s[pos]};
    for (int k = 0; k < 10; k++) begin
      cyc();
      checks++;
      if (bus.uo_out !== exp || bus.uio_out !== 8'd3) begin
        failures++; $display("FAIL freeze k=%0d got=%h/%0d exp=%h/3", k, bus.uo_out, bus.uio_out, exp);
      end
    end
    ena_v = 1'b1; apply();
    repeat (10) cyc();
    checks++;
    if (bus.uo_out[0] !== s[pos] || bus.uo_out[7:4] !== {s[pos+27], s[pos+28], s[pos+29], s[pos+30]}) begin
      failures++; $display("FAIL resume pos=%0d got=%h", pos, bus.uo_out);
    end
    checks++;
    if (bus.uo_out[1] !== 1'b1 || bus.uio_out !== 8'd3) begin
      failures++; $display("FAIL resume_lock got=%b/%0d exp=1/3", bus.uo_out[1], bus.uio_out);
    end
  endtask

  task automatic test_invert();
    int pulses = 0;
    do_reset();
    ext_loop = 1'b1;
    ctrl = 8'h0B; apply();
    checks++;
    if (bus.uo_out[0] !== ~s[0]) begin
      failures++; $display("FAIL inv_tx pos=0 got=%b exp=%b", bus.uo_out[0], ~s[0]);
    end
    for (int n = 1; n <= 100; n++) begin
      cyc();
      if (bus.uo_out[2] === 1'b1) pulses++;
      if (n <= 40) begin
        checks++;
        if (bus.uo_out[0] !== ~s[pos]) begin
          failures++; $display("FAIL inv_tx pos=%0d got=%b exp=%b", pos, bus.uo_out[0], ~s[pos]);
        end
      end
      if (n == 60) begin
        checks++;
        if (bus.uo_out[1] !== 1'b1) begin
          failures++; $display("FAIL inv_lock got=%b exp=1", bus.uo_out[1]);
        end
      end
    end
    checks++;
    if (pulses !== 0 || bus.uio_out !== 8'd0) begin
      failures++; $display("FAIL inv_errors pulses=%0d cnt=%0d exp=0/0", pulses, bus.uio_out);
    end
  endtask

  initial begin
    for (int i = 0; i < 31; i++) s[i] = 1'b1;
    for (int i = 31; i < 512; i++) s[i] = s[i-31] ^ s[i-28];
    test_reset();
    test_tx_sequence();
    test_lock();
    test_inject();
    test_saturate();
    test_freeze();
    test_invert();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end
endmodule
